// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed Booth multiplier / restoring divider with fixed WIDTH-cycle latency
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH:0] acc, acc_nx, sh, acc_init;
    logic [WIDTH-1:0] a, b, mag_a, mag_b, quo, res;
    logic [WIDTH:0] sum, diff;
    logic mul, start, last, exc;
    assign start = ctrl_MULT | ctrl_DIV;
    assign last = cnt == CNT_W'(WIDTH-1);
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = b[WIDTH-1] ? -b : b;
    assign acc_init = ctrl_MULT ? {{WIDTH{1'b0}}, data_operandB, 1'b0} : {{(WIDTH+1){1'b0}}, mag_a};
    // Booth adds into a WIDTH+1 guard so subtracting -2^(WIDTH-1) cannot wrap before the shift
    always_comb begin
        sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]}
            + (acc[1:0] == 2'b01 ? {a[WIDTH-1], a} : acc[1:0] == 2'b10 ? -{a[WIDTH-1], a} : '0);
        sh = {acc[2*WIDTH-1:0], 1'b0};
        diff = sh[2*WIDTH:WIDTH] - {1'b0, mag_b};
        acc_nx = mul ? {sum, acc[WIDTH:1]} : diff[WIDTH] ? sh : {diff, sh[WIDTH-1:1], 1'b1};
        quo = acc_nx[WIDTH-1:0];
        res = mul ? acc_nx[WIDTH:1] : b == '0 ? '0 : (a[WIDTH-1] ^ b[WIDTH-1]) ? -quo : quo;
        exc = mul ? acc_nx[2*WIDTH:WIDTH+1] != {WIDTH{acc_nx[WIDTH]}}
                  : b == '0 || (a == {1'b1, {(WIDTH-1){1'b0}}} && &b);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = start ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        data_resultRDY = state == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            acc <= '0;
            a <= '0;
            b <= '0;
            mul <= 1'b0;
            data_result <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            acc <= acc_init;
            a <= data_operandA;
            b <= data_operandB;
            mul <= ctrl_MULT;
            data_result <= '0;
            data_exception <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nx;
            if (last) begin
                data_result <= res;
                data_exception <= exc;
            end
        end
    end
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: directed vectors for the iterative multiply/divide unit
module tb_multdiv_iter;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] data_operandA = 0, data_operandB = 0;
    logic        ctrl_MULT = 0, ctrl_DIV = 0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;
    int n_vec = 0, n_err = 0;

    multdiv_iter dut (
        .clk(clk), .reset(reset),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(posedge clk);
        #1 ctrl_MULT = 0; ctrl_DIV = 0;
        data_operandA = $urandom; data_operandB = $urandom;
    endtask

    task automatic do_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee);
        int seen = 0, lat = -1;
        pulse(m, d, a, b);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, " cleared"}, data_result, 32'h0);
            if (data_resultRDY) begin
                seen++;
                if (seen == 1) begin
                    lat = k;
                    check({tag, " result"}, data_result, er);
                    check({tag, " exc"}, {31'b0, data_exception}, {31'b0, ee});
                end
            end
        end
        check({tag, " latency"}, lat, 32);
        check({tag, " rdy count"}, seen, 1);
        check({tag, " held"}, data_result, er);
    endtask

    initial begin
        int rdys;
        #1 check("reset result", data_result, 32'h0);
        check("reset rdy", {31'b0, data_resultRDY}, 32'h0);
        check("reset exc", {31'b0, data_exception}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1;
        do_op("mul 7*-6", 1, 0, 32'd7, -32'sd6, 32'hFFFFFFD6, 0);
        do_op("mul 2^16*2^16", 1, 0, 32'h00010000, 32'h00010000, 32'h0, 1);
        do_op("mul min*-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("mul -3*-5", 1, 0, -32'sd3, -32'sd5, 32'd15, 0);
        do_op("mul max*2", 1, 0, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1);
        do_op("mul min*1", 1, 0, 32'h80000000, 32'd1, 32'h80000000, 0);
        do_op("div -100/7", 0, 1, -32'sd100, 32'd7, 32'hFFFFFFF2, 0);
        do_op("div 100/-7", 0, 1, 32'd100, -32'sd7, 32'hFFFFFFF2, 0);
        do_op("div -100/-7", 0, 1, -32'sd100, -32'sd7, 32'd14, 0);
        do_op("div 7/100", 0, 1, 32'd7, 32'd100, 32'd0, 0);
        do_op("div min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("div min/2", 0, 1, 32'h80000000, 32'd2, 32'hC0000000, 0);
        do_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'd0, 1);
        pulse(0, 1, 32'd100, 32'd3);
        rdys = 0;
        repeat (9) begin
            @(negedge clk);
            if (data_resultRDY) rdys++;
        end
        check("abort early rdy", rdys, 0);
        do_op("abort mul 3*4", 1, 0, 32'd3, 32'd4, 32'd12, 0);
        do_op("both 6,3", 1, 1, 32'd6, 32'd3, 32'd18, 0);
        @(negedge clk);
        #2 reset = 0;
        #1 check("async reset result", data_result, 32'h0);
        @(negedge clk);
        reset = 1;
        pulse(0, 1, 32'd1000, 32'd7);
        repeat (14) @(negedge clk);
        reset = 0;
        #1 check("mid reset result", data_result, 32'h0);
        check("mid reset rdy", {31'b0, data_resultRDY}, 32'h0);
        check("mid reset exc", {31'b0, data_exception}, 32'h0);
        @(negedge clk);
        reset = 1;
        rdys = 0;
        repeat (45) begin
            @(negedge clk);
            if (data_resultRDY) rdys++;
        end
        check("post reset rdy", rdys, 0);
        do_op("mul 2*3", 1, 0, 32'd2, 32'd3, 32'd6, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
